// File: rtl/button_conditioner.sv
// Conditions raw push-buttons into clean control events for the tile-sort
// game logic: two-flop synchroniser, debounce, press/release edge pulses
// and auto-repeat on held keys. Every button is handled independently.
module button_conditioner #(
  parameter int                N_BTN           = 5,
  parameter int                DEBOUNCE_CYCLES = 1000000,
  parameter int                REPEAT_DELAY    = 25000000,
  parameter int                REPEAT_RATE     = 7500000,
  parameter logic [N_BTN-1:0]  REPEAT_MASK     = 5'b11101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_act
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TMR_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  // Synchroniser and debounce state
  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [DB_W-1:0]  cnt_q [N_BTN];
  logic [DB_W-1:0]  cnt_d [N_BTN];

  // Registered outputs
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] act_q, act_d;

  // Auto-repeat FSMs
  rep_state_e       state_q [N_BTN];
  rep_state_e       state_d [N_BTN];
  logic [TMR_W-1:0] timer_q [N_BTN];
  logic [TMR_W-1:0] timer_d [N_BTN];
  logic [N_BTN-1:0] rep_fire;

  // Debounce: the level follows the synchronised input only after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles; edge pulses and the
  // action pulse are derived from the next level so they coincide with it.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    // A repeat that lands on the cycle the level falls is dropped.
    act_d     = press_d | (rep_fire & level_d);
  end

  // Synchroniser, debounce counters and registered outputs
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      act_q     <= '0;
      // NOTE: the counter array is cleared explicitly; a stale count would
      // let a post-reset glitch reach the level early.
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      act_q     <= act_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Repeat FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= ST_IDLE;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  // Repeat FSM next state: the timer starts on the press and restarts after
  // each repeat; a release (or a masked button) always returns to idle.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      if (!REPEAT_MASK[i] || release_d[i]) begin
        state_d[i] = ST_IDLE;
        timer_d[i] = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (press_d[i]) begin
              state_d[i] = ST_DELAY;
              timer_d[i] = '0;
            end
          end
          ST_DELAY: begin
            if (timer_q[i] == DELAY_LAST) begin
              state_d[i] = ST_REPEAT;
              timer_d[i] = '0;
            end else begin
              timer_d[i] = timer_q[i] + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (timer_q[i] == RATE_LAST) begin
              timer_d[i] = '0;
            end else begin
              timer_d[i] = timer_q[i] + 1'b1;
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            timer_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Repeat FSM output: a repeat is due when the active interval expires
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rep_fire[i] = ((state_q[i] == ST_DELAY)  && (timer_q[i] == DELAY_LAST)) ||
                    ((state_q[i] == ST_REPEAT) && (timer_q[i] == RATE_LAST));
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_act     = act_q;

endmodule
